// File: rtl/flush_redirect_ctrl.sv
// ============================================================================
// Module   : flush_redirect_ctrl
// Purpose  : Flush/redirect sequencer for WB exceptions, ERTN and refetch,
//            with in-flight instruction-request discard tracking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flush_redirect_ctrl #(
  parameter int          CNT_W      = 2,
  parameter logic [5:0]  ECODE_TLBR = 6'h3F
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic        ertn_flush,
  input  logic        wb_refetch_flush,
  input  logic [31:0] wb_pc,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_tlbrentry,
  input  logic [31:0] csr_era,
  output logic        flush_all,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  input  logic        inst_req_fire,
  input  logic        inst_resp_fire,
  output logic        inst_req_allow,
  output logic        inst_resp_discard,
  output logic        ctrl_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REDIR = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W:0] MAX_OUT = (CNT_W+1)'((1 << CNT_W) - 1);

  state_t           state;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] discard_cnt;

  logic             any_event;
  logic             disc_now;
  logic             resp_to_out;
  logic [31:0]      target;
  logic [CNT_W-1:0] out_nxt;
  logic [CNT_W-1:0] discard_dec;
  logic [CNT_W-1:0] flush_discard;

  always_comb begin
    any_event   = wb_ex | ertn_flush | wb_refetch_flush;
    disc_now    = inst_resp_fire && (discard_cnt != '0);
    // A response with nothing outstanding is spurious and must not underflow.
    resp_to_out = inst_resp_fire && !disc_now && (out_cnt != '0);

    if (wb_ex)
      target = (wb_ecode == ECODE_TLBR) ? csr_tlbrentry : csr_eentry;
    else if (ertn_flush)
      target = csr_era;
    else
      target = wb_pc + 32'd4;

    out_nxt = out_cnt;
    if (inst_req_fire && !resp_to_out)
      out_nxt = out_cnt + CNT_W'(1);
    else if (!inst_req_fire && resp_to_out)
      out_nxt = out_cnt - CNT_W'(1);

    discard_dec   = discard_cnt - CNT_W'(disc_now);
    // Everything still in flight after this cycle becomes a discard.
    flush_discard = out_nxt + discard_dec;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= IDLE;
      out_cnt        <= '0;
      discard_cnt    <= '0;
      redirect_pc    <= 32'd0;
      redirect_valid <= 1'b0;
    end else if (any_event) begin
      state          <= REDIR;
      out_cnt        <= '0;
      discard_cnt    <= flush_discard;
      redirect_pc    <= target;
      redirect_valid <= 1'b1;
    end else begin
      out_cnt     <= out_nxt;
      discard_cnt <= discard_dec;
      case (state)
        REDIR: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            state          <= (discard_dec != '0) ? DRAIN : IDLE;
          end
        end
        DRAIN: begin
          if (discard_dec == '0)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign flush_all         = any_event;
  assign inst_resp_discard = disc_now;
  assign ctrl_busy         = (state != IDLE);
  assign inst_req_allow    = (state == IDLE) &&
                             (({1'b0, out_cnt} + {1'b0, discard_cnt}) < MAX_OUT);

endmodule

`default_nettype wire

// File: tb/tb_flush_redirect_ctrl.sv
// ============================================================================
// Module   : tb_flush_redirect_ctrl
// Purpose  : Directed self-checking bench for flush_redirect_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flush_redirect_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic        ertn_flush;
  logic        wb_refetch_flush;
  logic [31:0] wb_pc;
  logic [31:0] csr_eentry;
  logic [31:0] csr_tlbrentry;
  logic [31:0] csr_era;
  logic        flush_all;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        inst_req_fire;
  logic        inst_resp_fire;
  logic        inst_req_allow;
  logic        inst_resp_discard;
  logic        ctrl_busy;

  int n_checks = 0;
  int n_errors = 0;

  flush_redirect_ctrl #(.CNT_W(2), .ECODE_TLBR(6'h3F)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .wb_ex             (wb_ex),
    .wb_ecode          (wb_ecode),
    .ertn_flush        (ertn_flush),
    .wb_refetch_flush  (wb_refetch_flush),
    .wb_pc             (wb_pc),
    .csr_eentry        (csr_eentry),
    .csr_tlbrentry     (csr_tlbrentry),
    .csr_era           (csr_era),
    .flush_all         (flush_all),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .redirect_ready    (redirect_ready),
    .inst_req_fire     (inst_req_fire),
    .inst_resp_fire    (inst_resp_fire),
    .inst_req_allow    (inst_req_allow),
    .inst_resp_discard (inst_resp_discard),
    .ctrl_busy         (ctrl_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requests must never be issued while the controller withholds permission.
  always @(posedge clk) begin
    if (resetn && inst_req_fire)
      chk("req_while_blocked", {31'd0, inst_req_allow}, 32'd1);
  end

  initial begin
    resetn = 1'b0; wb_ex = 1'b0; wb_ecode = 6'h08; ertn_flush = 1'b0;
    wb_refetch_flush = 1'b0; wb_pc = 32'd0; csr_eentry = 32'h1C008000;
    csr_tlbrentry = 32'h1C00F000; csr_era = 32'h1C000100;
    redirect_ready = 1'b0; inst_req_fire = 1'b0; inst_resp_fire = 1'b0;

    tick(); tick();
    chk("rst_flush",  {31'd0, flush_all},         32'd0);
    chk("rst_rvalid", {31'd0, redirect_valid},    32'd0);
    chk("rst_rpc",    redirect_pc,                32'd0);
    chk("rst_allow",  {31'd0, inst_req_allow},    32'd1);
    chk("rst_disc",   {31'd0, inst_resp_discard}, 32'd0);
    chk("rst_busy",   {31'd0, ctrl_busy},         32'd0);
    resetn = 1'b1;

    // Two requests in flight, then a general exception.
    inst_req_fire = 1'b1; tick(); tick(); inst_req_fire = 1'b0;
    chk("t1_out2", 32'(dut.out_cnt), 32'd2);
    chk("t1_allow_at2", {31'd0, inst_req_allow}, 32'd1);
    wb_ex = 1'b1; wb_ecode = 6'h08; #1;
    chk("t1_flush_comb", {31'd0, flush_all}, 32'd1);
    tick(); wb_ex = 1'b0; #1;
    chk("t1_flush_drop", {31'd0, flush_all},      32'd0);
    chk("t1_rvalid",     {31'd0, redirect_valid}, 32'd1);
    chk("t1_rpc",        redirect_pc,             32'h1C008000);
    chk("t1_disc_cnt",   32'(dut.discard_cnt),    32'd2);
    chk("t1_allow",      {31'd0, inst_req_allow}, 32'd0);
    chk("t1_busy",       {31'd0, ctrl_busy},      32'd1);

    // Accept redirect, drain the two stale responses.
    redirect_ready = 1'b1; tick(); redirect_ready = 1'b0;
    chk("t2_rvalid_drain", {31'd0, redirect_valid}, 32'd0);
    chk("t2_busy_drain",   {31'd0, ctrl_busy},      32'd1);
    chk("t2_allow_drain",  {31'd0, inst_req_allow}, 32'd0);
    inst_resp_fire = 1'b1; #1;
    chk("t2_disc1", {31'd0, inst_resp_discard}, 32'd1);
    tick();
    chk("t2_busy_mid", {31'd0, ctrl_busy}, 32'd1);
    chk("t2_disc2", {31'd0, inst_resp_discard}, 32'd1);
    tick(); inst_resp_fire = 1'b0; #1;
    chk("t2_idle",     {31'd0, ctrl_busy},      32'd0);
    chk("t2_allow",    {31'd0, inst_req_allow}, 32'd1);
    chk("t2_disc_cnt", 32'(dut.discard_cnt),    32'd0);
    chk("t2_out_cnt",  32'(dut.out_cnt),        32'd0);
    chk("t2_rpc_hold", redirect_pc,             32'h1C008000);

    // TLB refill entry, immediate accept with nothing to discard.
    wb_ex = 1'b1; wb_ecode = 6'h3F; redirect_ready = 1'b1;
    tick(); wb_ex = 1'b0; #1;
    chk("t3_rvalid", {31'd0, redirect_valid}, 32'd1);
    chk("t3_rpc",    redirect_pc,             32'h1C00F000);
    tick();
    chk("t3_idle",    {31'd0, ctrl_busy},      32'd0);
    chk("t3_rvalid0", {31'd0, redirect_valid}, 32'd0);

    // Refetch wraps PC+4; then exception beats ERTN.
    wb_refetch_flush = 1'b1; wb_pc = 32'hFFFFFFFC; redirect_ready = 1'b0;
    tick(); wb_refetch_flush = 1'b0; #1;
    chk("t4_wrap", redirect_pc, 32'h00000000);
    redirect_ready = 1'b1; tick(); redirect_ready = 1'b0;
    wb_ex = 1'b1; wb_ecode = 6'h08; ertn_flush = 1'b1;
    tick(); wb_ex = 1'b0; ertn_flush = 1'b0; #1;
    chk("t4_prio", redirect_pc, 32'h1C008000);
    redirect_ready = 1'b1; tick(); redirect_ready = 1'b0;
    chk("t4_idle", {31'd0, ctrl_busy}, 32'd0);

    // Outstanding-request limit.
    inst_req_fire = 1'b1; tick(); tick(); tick(); inst_req_fire = 1'b0;
    chk("t5_out3",   32'(dut.out_cnt),        32'd3);
    chk("t5_block",  {31'd0, inst_req_allow}, 32'd0);
    inst_resp_fire = 1'b1; tick(); inst_resp_fire = 1'b0;
    chk("t5_out2",   32'(dut.out_cnt),        32'd2);
    chk("t5_allow",  {31'd0, inst_req_allow}, 32'd1);
    inst_req_fire = 1'b1; inst_resp_fire = 1'b1; tick();
    inst_req_fire = 1'b0;
    chk("t5_both", 32'(dut.out_cnt), 32'd2);
    tick(); tick(); tick(); inst_resp_fire = 1'b0;
    chk("t5_no_underflow", 32'(dut.out_cnt), 32'd0);

    // Flush with a simultaneous request and a live response.
    inst_req_fire = 1'b1; tick();
    inst_resp_fire = 1'b1; wb_refetch_flush = 1'b1; wb_pc = 32'h1C000010; #1;
    chk("t6_live_resp", {31'd0, inst_resp_discard}, 32'd0);
    tick(); inst_req_fire = 1'b0; inst_resp_fire = 1'b0; wb_refetch_flush = 1'b0; #1;
    chk("t6_disc_cnt", 32'(dut.discard_cnt), 32'd1);
    chk("t6_out_cnt",  32'(dut.out_cnt),     32'd0);
    chk("t6_rpc",      redirect_pc,          32'h1C000014);
    redirect_ready = 1'b1; tick(); redirect_ready = 1'b0;
    chk("t6_drain", {31'd0, ctrl_busy}, 32'd1);
    chk("t6_drain_rv", {31'd0, redirect_valid}, 32'd0);
    ertn_flush = 1'b1; tick(); ertn_flush = 1'b0; #1;
    chk("t6_ertn_rv",   {31'd0, redirect_valid}, 32'd1);
    chk("t6_ertn_rpc",  redirect_pc,             32'h1C000100);
    chk("t6_ertn_disc", 32'(dut.discard_cnt),    32'd1);
    redirect_ready = 1'b1; tick(); redirect_ready = 1'b0;
    chk("t6_drain2", {31'd0, ctrl_busy}, 32'd1);
    inst_resp_fire = 1'b1; #1;
    chk("t6_last_disc", {31'd0, inst_resp_discard}, 32'd1);
    tick(); inst_resp_fire = 1'b0; #1;
    chk("t6_idle",  {31'd0, ctrl_busy},      32'd0);
    chk("t6_allow", {31'd0, inst_req_allow}, 32'd1);

    // Reset in the middle of a drain.
    inst_req_fire = 1'b1; tick(); inst_req_fire = 1'b0;
    wb_ex = 1'b1; tick(); wb_ex = 1'b0;
    redirect_ready = 1'b1; tick(); redirect_ready = 1'b0;
    chk("t7_in_drain", {31'd0, ctrl_busy}, 32'd1);
    resetn = 1'b0; tick(); #1;
    chk("t7_busy",  {31'd0, ctrl_busy},      32'd0);
    chk("t7_disc",  32'(dut.discard_cnt),    32'd0);
    chk("t7_rpc",   redirect_pc,             32'd0);
    chk("t7_allow", {31'd0, inst_req_allow}, 32'd1);
    resetn = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/flush_redirect_ctrl.md
Name: flush_redirect_ctrl

Overview:
- Sequences pipeline flush and front-end redirect for exception entry, ERTN return and TLB-op refetch raised by the write-back stage.
- Selects the redirect target from CSR values, then holds it to the fetch stage until the fetch stage accepts it.
- Tracks outstanding instruction-bus requests so that responses to requests issued before the flush are discarded, not delivered.
- Sits between the WB stage / CSR file and the IF stage plus instruction bus interface.

Parameters:
- CNT_W, 2, width of outstanding-request counters; max outstanding = 2^CNT_W-1.
- ECODE_TLBR, 6'h3F, ecode value selecting the TLB-refill entry.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset; synchronous, active-low.
- wb_ex  in  1  exception committed in WB this cycle.
- wb_ecode  in  6  ecode of the WB exception.
- ertn_flush  in  1  ERTN committed in WB.
- wb_refetch_flush  in  1  TLB-op refetch committed in WB.
- wb_pc  in  32  PC of the WB instruction.
- csr_eentry  in  32  general exception entry.
- csr_tlbrentry  in  32  TLB-refill entry.
- csr_era  in  32  exception return address.
- flush_all  out  1  flush IF/ID/EX/MEM valid bits.
- redirect_valid  out  1  redirect request to IF.
- redirect_pc  out  32  redirect target.
- redirect_ready  in  1  IF accepts redirect.
- inst_req_fire  in  1  instruction address handshake this cycle.
- inst_resp_fire  in  1  instruction data handshake this cycle.
- inst_req_allow  out  1  IF may issue a new instruction request.
- inst_resp_discard  out  1  current response belongs to a flushed request; IF drops it.
- ctrl_busy  out  1  state != IDLE.

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE, out_cnt=0, discard_cnt=0, redirect_pc=0, redirect_valid=0. All outputs are then 0 except inst_req_allow=1.
- Event priority: wb_ex > ertn_flush > wb_refetch_flush. Lower-priority events in the same cycle are ignored.
- Target selection:
  - wb_ex with wb_ecode==ECODE_TLBR → csr_tlbrentry.
  - Other wb_ex → csr_eentry.
  - ertn → csr_era.
  - refetch → wb_pc+32'd4 (mod 2^32).
- flush_all = wb_ex|ertn_flush|wb_refetch_flush. It is combinational, same cycle, in any state.
- out_cnt update: +1 on req_fire only, -1 on resp_fire only, unchanged on both.
  - resp_fire with out_cnt==0 is ignored (counter stays at 0).
- Flush cycle (any event, any state):
  - redirect_pc <= target.
  - discard_cnt <= out_cnt + req_fire - (resp_fire & ~discard_this_cycle) + discard_cnt - (resp_fire & discard_this_cycle).
  - Net effect: every in-flight request, including one firing this cycle, is marked for discard.
  - out_cnt <= 0.
  - State <= REDIR.
  - A new event while in REDIR or DRAIN overrides the target and restarts REDIR.
- inst_resp_discard = inst_resp_fire & (discard_cnt!=0). A discarded response decrements discard_cnt, not out_cnt.
- States:
  - IDLE: redirect_valid=0. inst_req_allow = (out_cnt + discard_cnt < 2^CNT_W-1).
  - REDIR: redirect_valid=1, inst_req_allow=0.
    - redirect_ready=1 and no event → DRAIN if post-update discard_cnt != 0, else IDLE.
  - DRAIN: redirect_valid=0, inst_req_allow=0.
    - Moves to IDLE in the cycle after discard_cnt reaches 0, i.e. when the last discarded response fires, the next state is IDLE.
- redirect_pc holds its value until the next event. It is not cleared on return to IDLE.
- Requests firing while inst_req_allow=0 are a protocol violation; the bench asserts they never occur.
- Reset asserted mid-REDIR/DRAIN returns to the reset state immediately; pending discards are forgotten.

Test Plan:
- Reset, then 2 req_fire with no resp; wb_ex with ecode=6'h08, csr_eentry=0x1C008000 → flush_all=1 the same cycle; next cycle redirect_valid=1, redirect_pc=0x1C008000, discard_cnt=2, inst_req_allow=0.
- From that state: redirect_ready=1 → DRAIN; 2 resp_fire → inst_resp_discard=1 on both; IDLE after the second; inst_req_allow=1.
- wb_ex with ecode=6'h3F, tlbrentry=0x1C00F000 → redirect_pc=0x1C00F000. With 0 outstanding and redirect_ready=1 on the first REDIR cycle → IDLE the next cycle, no DRAIN.
- wb_refetch_flush with wb_pc=0xFFFFFFFC → redirect_pc=0x00000000. Simultaneous wb_ex and ertn with csr_era=0x1C000100, eentry=0x1C008000 → redirect_pc=0x1C008000.
- Outstanding limit: 3 req_fire with CNT_W=2 → inst_req_allow=0. One resp_fire → allow=1. Simultaneous req_fire+resp_fire → out_cnt unchanged.
- Flush in the same cycle as a req_fire and a non-discarded resp_fire with out_cnt=1 → discard_cnt=1. ertn arriving during DRAIN → back to REDIR with redirect_pc=csr_era; discards still counted.
